serial_peer: RTL and testbench

Host/terminal-side 8N1 UART peer for the PDP-8 console serial interface. It drives the CPU's `rx` line from a 4-deep character FIFO and captures characters sent on the CPU's `tx` line into a holding register with a valid/ack handshake. It acts as the far end of the console link in system builds and as the keyboard/printer model in CPU-level benches.

---
 rtl/serial_peer.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_serial_peer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_peer.sv
// serial_peer
// Host/terminal-side 8N1 UART peer for the PDP-8 console link. Characters
// pushed by the host are queued in a 4-entry FIFO and sent on tx_line
// (toward the CPU rx pin). Characters arriving on rx_line (from the CPU tx
// pin) are captured into a holding register with a valid/ack handshake.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   host_data     character to send, bit 0 first
//   host_valid    host_data valid this cycle
//   host_ready    FIFO not full (push on host_valid & host_ready)
//   tx_line       registered serial output, idles high
//   rx_line       asynchronous serial input
//   rx_data       last received character
//   rx_valid      rx_data holds an unconsumed character
//   rx_ack        consume the held character
//   rx_overrun    a character arrived while rx_valid was high
//   framing_error stop bit of the held character sampled low
//   busy          transmitter mid-frame or FIFO non-empty
module serial_peer #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] host_data,
  input  logic       host_valid,
  output logic       host_ready,
  output logic       tx_line,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = 16;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic [2:0] count_next;
  logic       push;
  logic       pop;

  assign push       = host_valid & host_ready;
  assign count_next = count + {2'b00, push} - {2'b00, pop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'h00;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      host_ready <= 1'b1;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= host_data;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count      <= count_next;
      host_ready <= (count_next != 3'd4);
    end
  end

  // ---------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t       tx_state, tx_state_next;
  logic [CW-1:0]   tx_cnt, tx_cnt_next;
  logic [2:0]      tx_idx, tx_idx_next;
  logic [7:0]      tx_shift, tx_shift_next;
  logic            tx_line_next;
  logic            busy_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= 3'd0;
      tx_shift <= 8'h00;
      tx_line  <= 1'b1;
      busy     <= 1'b0;
    end else begin
      tx_state <= tx_state_next;
      tx_cnt   <= tx_cnt_next;
      tx_idx   <= tx_idx_next;
      tx_shift <= tx_shift_next;
      tx_line  <= tx_line_next;
      busy     <= busy_next;
    end
  end

  // The line level is registered from the next state so that the start bit
  // appears on the edge that pops the character.
  always_comb begin
    tx_state_next = tx_state;
    tx_cnt_next   = tx_cnt;
    tx_idx_next   = tx_idx;
    tx_shift_next = tx_shift;
    pop           = 1'b0;

    case (tx_state)
      TX_IDLE: begin
        if (count != 3'd0) begin
          pop           = 1'b1;
          tx_shift_next = fifo_mem[rd_ptr];
          tx_cnt_next   = BIT_LAST;
          tx_state_next = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_cnt_next   = BIT_LAST;
          tx_idx_next   = 3'd0;
          tx_state_next = TX_DATA;
        end else begin
          tx_cnt_next = tx_cnt - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_next = BIT_LAST;
          if (tx_idx == 3'd7) begin
            tx_state_next = TX_STOP;
          end else begin
            tx_idx_next   = tx_idx + 3'd1;
            tx_shift_next = {1'b0, tx_shift[7:1]};
          end
        end else begin
          tx_cnt_next = tx_cnt - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          // Back-to-back frames: chain straight into the next start bit.
          if (count != 3'd0) begin
            pop           = 1'b1;
            tx_shift_next = fifo_mem[rd_ptr];
            tx_cnt_next   = BIT_LAST;
            tx_state_next = TX_START;
          end else begin
            tx_state_next = TX_IDLE;
          end
        end else begin
          tx_cnt_next = tx_cnt - 16'd1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase

    case (tx_state_next)
      TX_START: tx_line_next = 1'b0;
      TX_DATA:  tx_line_next = tx_shift_next[0];
      default:  tx_line_next = 1'b1;
    endcase

    busy_next = (tx_state_next != TX_IDLE) || (count_next != 3'd0);
  end

  // ---------------------------------------------------------------------
  // RX synchronizer
  // ---------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;

  // Reset to 0 so a receiver must see a genuine high before arming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
    end else begin
      rx_meta <= rx_line;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------
  // RX FSM and holding register
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       rx_state, rx_state_next;
  logic [CW-1:0]   rx_cnt, rx_cnt_next;
  logic [2:0]      rx_idx, rx_idx_next;
  logic [7:0]      rx_shift, rx_shift_next;
  logic [7:0]      rx_data_next;
  logic            rx_valid_next;
  logic            rx_overrun_next;
  logic            framing_error_next;
  logic            deliver;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state      <= RX_ARM;
      rx_cnt        <= '0;
      rx_idx        <= 3'd0;
      rx_shift      <= 8'h00;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      rx_overrun    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_state      <= rx_state_next;
      rx_cnt        <= rx_cnt_next;
      rx_idx        <= rx_idx_next;
      rx_shift      <= rx_shift_next;
      rx_data       <= rx_data_next;
      rx_valid      <= rx_valid_next;
      rx_overrun    <= rx_overrun_next;
      framing_error <= framing_error_next;
    end
  end

  // Sampling points sit at mid-bit: a half-bit wait after the start edge,
  // then full-bit steps. The stop sample hands off to IDLE at once so the
  // next start edge is caught within half a bit.
  always_comb begin
    rx_state_next      = rx_state;
    rx_cnt_next        = rx_cnt;
    rx_idx_next        = rx_idx;
    rx_shift_next      = rx_shift;
    rx_data_next       = rx_data;
    rx_valid_next      = rx_valid;
    rx_overrun_next    = rx_overrun;
    framing_error_next = framing_error;
    deliver            = 1'b0;

    case (rx_state)
      RX_ARM: begin
        if (rx_sync) rx_state_next = RX_IDLE;
      end
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_cnt_next   = HALF_LAST;
          rx_state_next = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (rx_sync) begin
            rx_state_next = RX_IDLE;
          end else begin
            rx_cnt_next   = BIT_LAST;
            rx_idx_next   = 3'd0;
            rx_state_next = RX_DATA;
          end
        end else begin
          rx_cnt_next = rx_cnt - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_next = {rx_sync, rx_shift[7:1]};
          rx_cnt_next   = BIT_LAST;
          if (rx_idx == 3'd7) rx_state_next = RX_STOP;
          else                rx_idx_next   = rx_idx + 3'd1;
        end else begin
          rx_cnt_next = rx_cnt - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          deliver       = 1'b1;
          rx_state_next = RX_IDLE;
        end else begin
          rx_cnt_next = rx_cnt - 16'd1;
        end
      end
      default: rx_state_next = RX_ARM;
    endcase

    // An ack on the delivery edge frees the holder, so the new character
    // replaces the old one instead of counting as an overrun.
    if (deliver) begin
      if (!rx_valid || rx_ack) begin
        rx_data_next       = rx_shift;
        framing_error_next = ~rx_sync;
        rx_valid_next      = 1'b1;
        rx_overrun_next    = 1'b0;
      end else begin
        rx_overrun_next = 1'b1;
      end
    end else if (rx_ack && rx_valid) begin
      rx_valid_next      = 1'b0;
      rx_overrun_next    = 1'b0;
      framing_error_next = 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_peer.sv
// tb_serial_peer
// Self-checking bench for serial_peer with CLKS_PER_BIT = 8. A behavioural
// model (character queue + frame position for TX, mid-bit sample schedule
// for RX) predicts every output each cycle; directed scenarios add literal
// expectations, followed by a randomized loopback phase.
module tb_serial_peer;

  localparam int C = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] host_data;
  logic       host_valid;
  logic       host_ready;
  logic       tx_line;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       framing_error;
  logic       busy;

  logic       rx_manual;
  logic       loop_en;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  assign rx_line = loop_en ? tx_line : rx_manual;

  serial_peer #(.CLKS_PER_BIT(C)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_data     (host_data),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .tx_line       (tx_line),
    .rx_line       (rx_line),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ack        (rx_ack),
    .rx_overrun    (rx_overrun),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  byte unsigned m_q[$];
  bit           m_active;
  int           m_pos;
  logic [9:0]   m_frame;
  bit           m_ready;
  bit           m_busy;
  bit           s1, s2, armed;
  int           f_start;
  int           m_cyc;
  logic [7:0]   f_data;
  logic [7:0]   m_data;
  bit           m_valid, m_ov, m_fe;

  task automatic modelReset();
    m_q.delete();
    m_active = 0; m_pos = 0; m_frame = 10'h3FF; m_ready = 1; m_busy = 0;
    s1 = 0; s2 = 0; armed = 0; f_start = -1; m_cyc = 0; f_data = 8'h00;
    m_data = 8'h00; m_valid = 0; m_ov = 0; m_fe = 0;
  endtask

  task automatic loadFrame();
    byte unsigned d;
    d = m_q.pop_front();
    m_frame = {1'b1, d, 1'b0};
    m_pos = 0;
    m_active = 1;
  endtask

  task automatic modelStep();
    bit pushed;
    byte unsigned pd;
    bit v, deliver;
    int off;
    pushed = host_valid && m_ready;
    pd = host_data;
    if (m_active) begin
      m_pos++;
      if (m_pos == 10 * C) begin
        if (m_q.size() > 0) loadFrame();
        else m_active = 0;
      end
    end else if (m_q.size() > 0) begin
      loadFrame();
    end
    if (pushed) m_q.push_back(pd);
    m_ready = (m_q.size() != 4);
    m_busy = m_active || (m_q.size() != 0);

    v = s2; s2 = s1; s1 = rx_line;
    deliver = 0;
    if (!armed) begin
      if (v) armed = 1;
    end else if (f_start < 0) begin
      if (!v) f_start = m_cyc;
    end else begin
      off = m_cyc - f_start;
      if (off == C / 2) begin
        if (v) f_start = -1;
      end else if (off == C / 2 + 9 * C) begin
        deliver = 1;
        f_start = -1;
      end else if (off > C / 2 && ((off - C / 2) % C) == 0) begin
        f_data[(off - C / 2) / C - 1] = v;
      end
    end
    if (deliver) begin
      if (!m_valid || rx_ack) begin
        m_data = f_data; m_fe = !v; m_valid = 1; m_ov = 0;
      end else begin
        m_ov = 1;
      end
    end else if (rx_ack && m_valid) begin
      m_valid = 0; m_ov = 0; m_fe = 0;
    end
    m_cyc++;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) modelReset();
      else modelStep();
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    checkOutput("tx_line", tx_line, m_active ? m_frame[m_pos / C] : 1'b1);
    checkOutput("host_ready", host_ready, m_ready);
    checkOutput("busy", busy, m_busy);
    checkOutput("rx_valid", rx_valid, m_valid);
    checkOutput("rx_data", rx_data, m_data);
    checkOutput("rx_overrun", rx_overrun, m_ov);
    checkOutput("framing_error", framing_error, m_fe);
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic applyStimulus(input logic [7:0] d, input bit hold, output int acc_cyc);
    int n;
    n = 0;
    while (!host_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("host_ready_wait", host_ready, 1'b1);
    host_valid = 1'b1;
    host_data = d;
    @(negedge clk);
    acc_cyc = cyc;
    if (!hold) host_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_manual = bits[b];
      repeat (C) @(negedge clk);
    end
    rx_manual = 1'b1;
  endtask

  task automatic waitBusyLow(output int at);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_wait", busy, 1'b0);
    at = cyc;
  endtask

  task automatic waitRxValid(output int at);
    int n;
    n = 0;
    while (!rx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rx_valid_wait", rx_valid, 1'b1);
    at = cyc;
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  initial begin
    int t0, t1, t_end, lows;
    logic [9:0] pat41;
    reset = 1'b0; host_valid = 1'b0; host_data = 8'h00;
    rx_ack = 1'b0; rx_manual = 1'b0; loop_en = 1'b0;

    // Reset state, with rx_line held low through release.
    repeat (3) @(negedge clk);
    checkOutput("reset_tx_line", tx_line, 1'b1);
    checkOutput("reset_host_ready", host_ready, 1'b1);
    checkOutput("reset_rx_valid", rx_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    #2 reset = 1'b1;
    repeat (20) @(negedge clk);
    rx_manual = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("arm_no_char", rx_valid, 1'b0);

    // Single character 0x41: exact bit pattern and busy duration.
    pat41 = 10'b1010000010;
    applyStimulus(8'h41, 1'b0, t0);
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < C; k++) begin
        @(negedge clk);
        checkOutput("frame41_bit", tx_line, pat41[b]);
      end
    end
    checkOutput("busy_before_end", busy, 1'b1);
    @(negedge clk);
    checkOutput("busy_after_end", busy, 1'b0);
    checkOutput("busy_len_41", 8'(cyc - t0), 8'd81);

    // Five pushes with host_valid held: FIFO fills, frames are contiguous.
    repeat (5) @(negedge clk);
    applyStimulus(8'h55, 1'b1, t0);
    applyStimulus(8'hAA, 1'b1, t1);
    applyStimulus(8'h0F, 1'b1, t1);
    applyStimulus(8'hF0, 1'b1, t1);
    applyStimulus(8'h33, 1'b1, t1);
    host_valid = 1'b0;
    checkOutput("full_host_ready", host_ready, 1'b0);
    waitBusyLow(t_end);
    checkOutput("busy_len_5", 16'(t_end - t0) == 16'd401, 1'b1);

    // Loopback: delivery, latency, overrun, ack.
    repeat (10) @(negedge clk);
    loop_en = 1'b1;
    repeat (10) @(negedge clk);
    applyStimulus(8'h8D, 1'b0, t0);
    waitRxValid(t1);
    checkOutput("loop_rx_data", rx_data, 8'h8D);
    checkOutput("loop_fe", framing_error, 1'b0);
    checkOutput("rx_latency", 8'(t1 - t0), 8'd80);
    applyStimulus(8'h3C, 1'b0, t0);
    waitBusyLow(t_end);
    repeat (10) @(negedge clk);
    checkOutput("overrun_set", rx_overrun, 1'b1);
    checkOutput("overrun_data_kept", rx_data, 8'h8D);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    checkOutput("ack_valid", rx_valid, 1'b0);
    checkOutput("ack_overrun", rx_overrun, 1'b0);
    checkOutput("ack_fe", framing_error, 1'b0);

    // Framing error: 0x7E with stop bit 0.
    loop_en = 1'b0;
    rx_manual = 1'b1;
    repeat (20) @(negedge clk);
    sendFrame(8'h7E, 1'b0);
    waitRxValid(t1);
    checkOutput("fe_rx_data", rx_data, 8'h7E);
    checkOutput("fe_flag", framing_error, 1'b1);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;

    // Two-cycle glitch on an idle line.
    repeat (30) @(negedge clk);
    rx_manual = 1'b0;
    repeat (2) @(negedge clk);
    rx_manual = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("glitch_no_char", rx_valid, 1'b0);

    // Reset during data bit 3 (frame bit 4) of a transmission.
    applyStimulus(8'hA5, 1'b0, t0);
    applyStimulus(8'h5A, 1'b0, t1);
    while (cyc < t0 + 36) @(negedge clk);
    checkOutput("pre_reset_tx_low", tx_line, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_async_tx", tx_line, 1'b1);
    checkOutput("reset_async_busy", busy, 1'b0);
    checkOutput("reset_async_ready", host_ready, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!tx_line) lows++;
    end
    checkOutput("fifo_flushed", 8'(lows), 8'd0);

    // Randomized loopback traffic with random acks.
    loop_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      host_valid = ($urandom_range(0, 2) == 0);
      host_data = 8'($urandom);
      rx_ack = ($urandom_range(0, 11) == 0);
    end
    host_valid = 1'b0;
    rx_ack = 1'b0;
    repeat (1000) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
